pwm_fan_ctrl_multi: RTL and testbench

//  N-channel PWM fan controller and parametrised successor of the single-channel 8-bit fan PWM.
//  - One shared prescaler and one shared period counter.
//  - Period is programmable; per-channel duty values are shadowed.
//  - Optional soft-start ramp per channel.
//  - Sits behind the AXI register slice; drives fan PWM pins directly.

---
 rtl/pwm_fan_ctrl_multi_if.sv | 26 ++
 rtl/pwm_fan_ctrl_multi.sv | 100 ++++++++++
 tb/tb_pwm_fan_ctrl_multi.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_fan_ctrl_multi_if.sv
// Register-side bundle of the multi-channel fan PWM: control levels in, PWM pins and readback out.
interface pwm_fan_ctrl_multi_if #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
);
  // No valid/ready pair: every control input is a level sampled on each clk edge,
  // and a new duty or period is taken up only at the next period wrap.
  logic                      enable;
  logic [PRESC_W-1:0]        prescale;
  logic [CNT_W-1:0]          period;
  logic [NUM_CH*CNT_W-1:0]   duty;
  logic [NUM_CH-1:0]         pwm_out;
  logic                      period_start;
  logic [NUM_CH*CNT_W-1:0]   duty_active;

  modport master (
    output enable, prescale, period, duty,
    input  pwm_out, period_start, duty_active
  );

  modport slave (
    input  enable, prescale, period, duty,
    output pwm_out, period_start, duty_active
  );
endinterface

// File: rtl/pwm_fan_ctrl_multi.sv
// N-channel fan PWM: shared prescaler and period counter, shadowed period/duty,
// optional per-channel soft-start ramp applied once per period.
module pwm_fan_ctrl_multi #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 8,
  parameter int PRESC_W   = 8,
  parameter int RAMP_STEP = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pwm_fan_ctrl_multi_if.slave  bus
);

  localparam int STEP_MAX = (1 << CNT_W) - 1;
  localparam int STEP_INT = (RAMP_STEP > STEP_MAX) ? STEP_MAX : RAMP_STEP;
  localparam logic [CNT_W-1:0] STEP = CNT_W'(STEP_INT);

  logic [PRESC_W-1:0] presc_cnt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   period_sh;
  logic [CNT_W-1:0]   target     [NUM_CH];
  logic [CNT_W-1:0]   active     [NUM_CH];
  logic [CNT_W-1:0]   active_nxt [NUM_CH];
  logic [NUM_CH-1:0]  pwm_q;
  logic               period_start_q;
  logic               en_d;
  logic               rise;
  logic               tick;
  logic               wrap;

  assign rise = bus.enable && !en_d;
  assign tick = bus.enable && (presc_cnt == bus.prescale);
  // An enable rise is handled exactly like a wrap so the first period is a full one.
  assign wrap = rise || (tick && (cnt >= period_sh));

  // Ramp toward the previously latched target; differences are taken in the
  // direction that cannot underflow, so no extra carry bit is needed.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      active_nxt[i] = target[i];
      if (RAMP_STEP != 0) begin
        if (active[i] < target[i]) begin
          active_nxt[i] = active[i] +
            (((target[i] - active[i]) > STEP) ? STEP : (target[i] - active[i]));
        end else if (active[i] > target[i]) begin
          active_nxt[i] = active[i] -
            (((active[i] - target[i]) > STEP) ? STEP : (active[i] - target[i]));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt      <= '0;
      cnt            <= '0;
      period_sh      <= '0;
      en_d           <= 1'b0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        target[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      en_d           <= bus.enable;
      period_start_q <= wrap;

      if (!bus.enable || rise) begin
        presc_cnt <= '0;
        cnt       <= '0;
      end else begin
        presc_cnt <= (presc_cnt >= bus.prescale) ? '0 : presc_cnt + 1'b1;
        if (tick) begin
          cnt <= (cnt >= period_sh) ? '0 : cnt + 1'b1;
        end
      end

      if (wrap) begin
        period_sh <= bus.period;
        for (int i = 0; i < NUM_CH; i++) begin
          target[i] <= bus.duty[i*CNT_W +: CNT_W];
          active[i] <= active_nxt[i];
        end
      end

      for (int i = 0; i < NUM_CH; i++) begin
        pwm_q[i] <= bus.enable && (cnt < active[i]);
      end
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = period_start_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_readback
    assign bus.duty_active[g*CNT_W +: CNT_W] = active[g];
  end

endmodule

// File: tb/tb_pwm_fan_ctrl_multi.sv
// Directed bench for pwm_fan_ctrl_multi: one instance without ramp, one with RAMP_STEP=2,
// both fed the same control inputs.
module tb_pwm_fan_ctrl_multi;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;
  int hi0 [4];
  int hir [4];
  int ps_cnt;

  pwm_fan_ctrl_multi_if #(.NUM_CH(4), .CNT_W(8), .PRESC_W(8)) bus0 ();
  pwm_fan_ctrl_multi_if #(.NUM_CH(4), .CNT_W(8), .PRESC_W(8)) bus_r ();

  assign bus_r.enable   = bus0.enable;
  assign bus_r.prescale = bus0.prescale;
  assign bus_r.period   = bus0.period;
  assign bus_r.duty     = bus0.duty;

  pwm_fan_ctrl_multi #(.NUM_CH(4), .CNT_W(8), .PRESC_W(8), .RAMP_STEP(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  pwm_fan_ctrl_multi #(.NUM_CH(4), .CNT_W(8), .PRESC_W(8), .RAMP_STEP(2)) dut_r (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_r)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver / sampling tasks
  task automatic sample_once();
    for (int c = 0; c < 4; c++) begin
      if (bus0.pwm_out[c] === 1'b1) hi0[c]++;
      if (bus_r.pwm_out[c] === 1'b1) hir[c]++;
    end
    if (bus0.period_start === 1'b1) ps_cnt++;
  endtask

  task automatic measure(input int n, input bit clear);
    if (clear) begin
      for (int c = 0; c < 4; c++) begin
        hi0[c] = 0;
        hir[c] = 0;
      end
      ps_cnt = 0;
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sample_once();
    end
  endtask

  // Counts clocks up to and including the next period_start.
  task automatic measure_period(output int len);
    for (int c = 0; c < 4; c++) begin
      hi0[c] = 0;
      hir[c] = 0;
    end
    ps_cnt = 0;
    len = 0;
    do begin
      @(negedge clk);
      sample_once();
      len++;
    end while (bus0.period_start !== 1'b1 && len < 300);
  endtask

  task automatic wait_ps(input string name);
    int k;
    k = 0;
    while (k < 300) begin
      @(negedge clk);
      if (bus0.period_start === 1'b1) break;
      k++;
    end
    n_checks++;
    if (k >= 300) begin
      n_fail++;
      $display("FAIL %s: no period_start within 300 clk", name);
    end
  endtask

  task automatic restart(input logic [7:0] pre, input logic [7:0] per, input logic [31:0] d);
    bus0.enable = 1'b0;
    @(negedge clk);
    bus0.prescale = pre;
    bus0.period   = per;
    bus0.duty     = d;
    bus0.enable   = 1'b1;
  endtask

  // scenarios
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus0.pwm_out !== 4'h0) begin
      n_fail++; $display("FAIL reset_pwm: got %h expected 0", bus0.pwm_out);
    end
    n_checks++;
    if (bus0.period_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_ps: got %b expected 0", bus0.period_start);
    end
    n_checks++;
    if (bus0.duty_active !== 32'h0) begin
      n_fail++; $display("FAIL reset_active: got %h expected 0", bus0.duty_active);
    end
    n_checks++;
    if (bus_r.duty_active !== 32'h0) begin
      n_fail++; $display("FAIL reset_active_ramp: got %h expected 0", bus_r.duty_active);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_duty_patterns();
    int exp_hi [4] = '{0, 3, 9, 10};
    int len;
    restart(8'd0, 8'd9, {8'd10, 8'd9, 8'd3, 8'd0});
    wait_ps("dp_ps1");
    // active lags the target by one period: first wrap applies the old target 0
    n_checks++;
    if (bus0.duty_active !== 32'h0) begin
      n_fail++; $display("FAIL dp_lag: got %h expected 0", bus0.duty_active);
    end
    wait_ps("dp_ps2");
    n_checks++;
    if (bus0.duty_active !== 32'h0a09_0300) begin
      n_fail++; $display("FAIL dp_active: got %h expected 0a090300", bus0.duty_active);
    end
    measure_period(len);
    n_checks++;
    if (len !== 10) begin
      n_fail++; $display("FAIL dp_len: got %0d expected 10", len);
    end
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (hi0[c] !== exp_hi[c]) begin
        n_fail++; $display("FAIL dp_high_ch%0d: got %0d expected %0d", c, hi0[c], exp_hi[c]);
      end
    end
  endtask

  task automatic test_prescale();
    int len;
    restart(8'd3, 8'd4, {4{8'd2}});
    wait_ps("pre_ps1");
    wait_ps("pre_ps2");
    measure_period(len);
    n_checks++;
    if (len !== 20) begin
      n_fail++; $display("FAIL pre_len: got %0d expected 20", len);
    end
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (hi0[c] !== 8) begin
        n_fail++; $display("FAIL pre_high_ch%0d: got %0d expected 8", c, hi0[c]);
      end
    end
  endtask

  task automatic test_deferred();
    int len;
    restart(8'd0, 8'd9, {4{8'd2}});
    wait_ps("def_ps1");
    wait_ps("def_ps2");
    measure(4, 1'b1);
    bus0.duty   = {4{8'd7}};
    bus0.period = 8'd14;
    measure(6, 1'b0);
    n_checks++;
    if (bus0.period_start !== 1'b1) begin
      n_fail++; $display("FAIL def_wrap_at_10: got %b expected 1", bus0.period_start);
    end
    n_checks++;
    if (hi0[0] !== 2) begin
      n_fail++; $display("FAIL def_cur_high: got %0d expected 2", hi0[0]);
    end
    n_checks++;
    if (bus0.duty_active !== {4{8'd2}}) begin
      n_fail++; $display("FAIL def_active_lag: got %h expected 02020202", bus0.duty_active);
    end
    measure_period(len);
    n_checks++;
    if (len !== 15 || hi0[1] !== 2) begin
      n_fail++; $display("FAIL def_p1: got len %0d high %0d expected 15 2", len, hi0[1]);
    end
    measure_period(len);
    n_checks++;
    if (len !== 15 || hi0[2] !== 7) begin
      n_fail++; $display("FAIL def_p2: got len %0d high %0d expected 15 7", len, hi0[2]);
    end
  endtask

  task automatic test_period_zero();
    int exp_hi [4] = '{0, 8, 8, 8};
    restart(8'd0, 8'd0, {8'd1, 8'd1, 8'd1, 8'd0});
    repeat (3) @(negedge clk);
    measure(8, 1'b1);
    n_checks++;
    if (ps_cnt !== 8) begin
      n_fail++; $display("FAIL pz_ps: got %0d expected 8", ps_cnt);
    end
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (hi0[c] !== exp_hi[c]) begin
        n_fail++; $display("FAIL pz_high_ch%0d: got %0d expected %0d", c, hi0[c], exp_hi[c]);
      end
    end
  endtask

  task automatic test_ramp();
    logic [7:0] up_seq [6] = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd7, 8'd7};
    logic [7:0] dn_seq [5] = '{8'd7, 8'd5, 8'd3, 8'd1, 8'd1};
    @(negedge clk);
    rst_n = 1'b0;
    bus0.enable = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus_r.duty_active !== 32'h0) begin
      n_fail++; $display("FAIL ramp_reset: got %h expected 0", bus_r.duty_active);
    end
    rst_n = 1'b1;
    bus0.prescale = 8'd0;
    bus0.period   = 8'd9;
    bus0.duty     = {4{8'd7}};
    @(negedge clk);
    bus0.enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_ps("ramp_up_ps");
      n_checks++;
      if (bus_r.duty_active !== {4{up_seq[k]}}) begin
        n_fail++; $display("FAIL ramp_up_%0d: got %h expected %0d", k, bus_r.duty_active, up_seq[k]);
      end
      if (k == 1) begin
        n_checks++;
        if (bus0.duty_active !== {4{8'd7}}) begin
          n_fail++; $display("FAIL ramp_noramp_jump: got %h expected 07070707", bus0.duty_active);
        end
      end
      if (k == 2) begin
        measure(9, 1'b1);
        n_checks++;
        if (hir[3] !== 4) begin
          n_fail++; $display("FAIL ramp_high4: got %0d expected 4", hir[3]);
        end
      end
    end
    bus0.duty = {4{8'd1}};
    for (int k = 0; k < 5; k++) begin
      wait_ps("ramp_dn_ps");
      n_checks++;
      if (bus_r.duty_active !== {4{dn_seq[k]}}) begin
        n_fail++; $display("FAIL ramp_dn_%0d: got %h expected %0d", k, bus_r.duty_active, dn_seq[k]);
      end
    end
  endtask

  task automatic test_enable();
    int len;
    restart(8'd0, 8'd9, {4{8'd5}});
    wait_ps("en_ps1");
    wait_ps("en_ps2");
    wait_ps("en_ps3");
    n_checks++;
    if (bus0.duty_active !== {4{8'd5}} || bus_r.duty_active !== {4{8'd5}}) begin
      n_fail++; $display("FAIL en_pre_active: got %h %h expected 05050505", bus0.duty_active, bus_r.duty_active);
    end
    measure(3, 1'b1);
    bus0.enable = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus0.pwm_out !== 4'h0 || bus_r.pwm_out !== 4'h0) begin
      n_fail++; $display("FAIL en_off_pwm: got %h %h expected 0", bus0.pwm_out, bus_r.pwm_out);
    end
    measure(20, 1'b1);
    n_checks++;
    if (ps_cnt !== 0 || hi0[0] !== 0 || hir[0] !== 0) begin
      n_fail++; $display("FAIL en_off_idle: got ps %0d high %0d %0d expected 0 0 0", ps_cnt, hi0[0], hir[0]);
    end
    n_checks++;
    if (bus0.duty_active !== {4{8'd5}} || bus_r.duty_active !== {4{8'd5}}) begin
      n_fail++; $display("FAIL en_off_retain: got %h %h expected 05050505", bus0.duty_active, bus_r.duty_active);
    end
    bus0.enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus0.period_start !== 1'b1) begin
      n_fail++; $display("FAIL en_rise_ps: got %b expected 1", bus0.period_start);
    end
    n_checks++;
    if (bus0.duty_active !== {4{8'd5}} || bus_r.duty_active !== {4{8'd5}}) begin
      n_fail++; $display("FAIL en_rise_active: got %h %h expected 05050505", bus0.duty_active, bus_r.duty_active);
    end
    measure_period(len);
    n_checks++;
    if (len !== 10 || hi0[0] !== 5) begin
      n_fail++; $display("FAIL en_first_period: got len %0d high %0d expected 10 5", len, hi0[0]);
    end
  endtask

  task automatic test_async_reset();
    int len;
    bus0.duty = {4{8'd9}};
    wait_ps("ar_ps1");
    wait_ps("ar_ps2");
    n_checks++;
    if (bus_r.duty_active !== {4{8'd7}}) begin
      n_fail++; $display("FAIL ar_midramp: got %h expected 07070707", bus_r.duty_active);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus0.pwm_out !== 4'hf) begin
      n_fail++; $display("FAIL ar_pre_high: got %h expected f", bus0.pwm_out);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus0.pwm_out !== 4'h0 || bus_r.pwm_out !== 4'h0 || bus0.period_start !== 1'b0) begin
      n_fail++; $display("FAIL ar_async_low: got %h %h %b expected 0 0 0", bus0.pwm_out, bus_r.pwm_out, bus0.period_start);
    end
    n_checks++;
    if (bus0.duty_active !== 32'h0 || bus_r.duty_active !== 32'h0) begin
      n_fail++; $display("FAIL ar_readback: got %h %h expected 0", bus0.duty_active, bus_r.duty_active);
    end
    #3 rst_n = 1'b1;
    wait_ps("ar_restart_ps1");
    n_checks++;
    if (bus0.duty_active !== 32'h0 || bus_r.duty_active !== 32'h0) begin
      n_fail++; $display("FAIL ar_restart_lag: got %h %h expected 0", bus0.duty_active, bus_r.duty_active);
    end
    wait_ps("ar_restart_ps2");
    n_checks++;
    if (bus0.duty_active !== {4{8'd9}} || bus_r.duty_active !== {4{8'd2}}) begin
      n_fail++; $display("FAIL ar_restart_active: got %h %h expected 09090909 02020202", bus0.duty_active, bus_r.duty_active);
    end
    measure_period(len);
    n_checks++;
    if (len !== 10 || hi0[0] !== 9 || hir[0] !== 2) begin
      n_fail++; $display("FAIL ar_restart_period: got len %0d high %0d %0d expected 10 9 2", len, hi0[0], hir[0]);
    end
  endtask

  // sequence and report
  initial begin
    rst_n         = 1'b0;
    bus0.enable   = 1'b0;
    bus0.prescale = 8'd0;
    bus0.period   = 8'd0;
    bus0.duty     = 32'h0;
    test_reset();
    test_duty_patterns();
    test_prescale();
    test_deferred();
    test_period_zero();
    test_ramp();
    test_enable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
